// File: rtl/mem_pkg.sv
// Shared types and default address map for the boot-loaded memory responder.
// No logic; constants only.
package mem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] PROT_LIMIT_DEF = 8'h7F;
  localparam logic [7:0] IO_ADDR_DEF    = 8'hFF;

endpackage

// File: rtl/mem_array.sv
// 256x8 storage: one synchronous write port, asynchronous read port.
// Write lands on the clock edge, read is combinational; never stalls. Contents survive reset.
module mem_array
  import mem_pkg::*;
(
  input  logic       clock,
  input  logic       i_we,
  input  logic [7:0] i_waddr,
  input  logic [7:0] i_wdat,
  input  logic [7:0] i_raddr,
  output logic [7:0] o_rdat
);

  logic [7:0] r_mem [256];

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdat;
    end
  end

  assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: streams a boot image in LOAD, then serves processor bus reads/writes in RUN.
// Reads are combinational, writes take effect on the next edge; loader is always ready in LOAD.
module mem_responder
  import mem_pkg::*;
#(
  parameter logic [7:0] PROT_LIMIT = PROT_LIMIT_DEF,
  parameter logic [7:0] IO_ADDR    = IO_ADDR_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] mar,
  input  logic       we,
  inout  wire  [7:0] mbr,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  input  logic       ld_last,
  output logic       ld_ready,
  output logic       cpu_hold,
  output logic [7:0] io_out,
  output logic       wr_fault
);

  state_t     r_state;
  logic [7:0] r_ld_addr;
  logic [7:0] r_io_out;
  logic       r_we_q;
  logic       r_wr_fault;

  logic       w_run;
  logic       w_ld_acc;
  logic       w_ld_done;
  logic       w_bus_wr;
  logic       w_prot_hit;
  logic       w_io_hit;
  logic       w_mem_we;
  logic [7:0] w_mem_waddr;
  logic [7:0] w_mem_wdat;
  logic [7:0] w_mem_rdat;
  logic [7:0] w_rd_dat;

  assign w_run      = (r_state == RUN);
  assign w_ld_acc   = !w_run && ld_valid;
  assign w_ld_done  = w_ld_acc && (ld_last || (r_ld_addr == 8'hFF));
  // Edge-detect the write strobe so a held-high we commits exactly once.
  assign w_bus_wr   = w_run && we && !r_we_q;
  assign w_prot_hit = w_bus_wr && (mar <= PROT_LIMIT);
  assign w_io_hit   = w_bus_wr && !w_prot_hit && (mar == IO_ADDR);

  assign w_mem_we    = w_ld_acc || (w_bus_wr && !w_prot_hit && !w_io_hit);
  assign w_mem_waddr = w_run ? mar : r_ld_addr;
  assign w_mem_wdat  = w_run ? mbr : ld_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= LOAD;
      r_ld_addr  <= 8'h00;
      r_we_q     <= 1'b0;
      r_io_out   <= 8'h00;
      r_wr_fault <= 1'b0;
    end else begin
      r_we_q <= we;
      if (w_ld_done) begin
        r_state <= RUN;
      end
      if (w_ld_acc && (r_ld_addr != 8'hFF)) begin
        r_ld_addr <= r_ld_addr + 8'h01;
      end
      if (w_io_hit) begin
        r_io_out <= mbr;
      end
      if (w_prot_hit) begin
        r_wr_fault <= 1'b1;
      end
    end
  end

  mem_array u_mem (
    .clock   (clock),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_waddr),
    .i_wdat  (w_mem_wdat),
    .i_raddr (mar),
    .o_rdat  (w_mem_rdat)
  );

  assign w_rd_dat = (mar == IO_ADDR) ? r_io_out : w_mem_rdat;
  assign mbr      = (w_run && !we) ? w_rd_dat : 8'bzzzz_zzzz;

  assign ld_ready = !w_run;
  assign cpu_hold = !w_run;
  assign io_out   = r_io_out;
  assign wr_fault = r_wr_fault;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter PROT_LIMIT, default 8'h7F, meaning the highest write-protected address during RUN.
REQ-002 The block SHALL have parameter IO_ADDR, default 8'hFF, meaning the address of the output port register.
REQ-003 clock  input  1  system clock, all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mar  input  8  bus address from the processor.
REQ-006 we  input  1  processor write strobe; processor drives mbr while high.
REQ-007 mbr  inout  8  shared data bus; block drives it only per REQ-016.
REQ-008 ld_valid  input  1  loader byte valid.
REQ-009 ld_data  input  8  loader byte.
REQ-010 ld_last  input  1  marks final loader byte, qualified by ld_valid.
REQ-011 ld_ready  output  1  block accepts a loader byte this cycle.
REQ-012 cpu_hold  output  1  processor must be held in reset while high.
REQ-013 io_out  output  8  output port register.
REQ-014 wr_fault  output  1  sticky flag for a write attempt to the protected region.

Function
REQ-015 The block SHALL have two states: LOAD (entered on reset) and RUN; RUN is left only by reset.
REQ-016 The block SHALL drive mbr only in RUN with we low: combinational read, mbr = io_out when mar == IO_ADDR, else mem[mar]; otherwise mbr is high-Z.
REQ-017 In LOAD, ld_ready = 1 and cpu_hold = 1; in RUN, ld_ready = 0 and cpu_hold = 0, both registered from state.
REQ-018 In LOAD, on each rising edge with ld_valid high, the block SHALL write ld_data to mem[ld_addr] and increment the 8-bit ld_addr.
REQ-019 On a LOAD accept with ld_last high, or with ld_addr == 8'hFF, the byte SHALL be written and the state SHALL become RUN on the same edge; ld_addr is not incremented past 8'hFF.
REQ-020 ld_valid, ld_data and ld_last SHALL be ignored in RUN.
REQ-021 The block SHALL register we into we_q each cycle; a bus write occurs only on an edge where we = 1 and we_q = 0, so a held-high we writes exactly once.
REQ-022 For a RUN bus write with mar <= PROT_LIMIT, memory SHALL be unchanged and wr_fault SHALL be set to 1.
REQ-023 For a RUN bus write with mar == IO_ADDR, io_out SHALL load mbr and memory SHALL be unchanged.
REQ-024 For any other RUN bus write, mem[mar] SHALL load mbr; the new value is readable in the following cycle.
REQ-025 wr_fault SHALL remain 1 until reset.
REQ-026 In LOAD, we SHALL be ignored and we_q still updates.

Reset
REQ-027 Asynchronous reset SHALL set state = LOAD, ld_addr = 0, we_q = 0, io_out = 8'h00 and wr_fault = 0.
REQ-028 During and after reset, ld_ready SHALL be 1, cpu_hold SHALL be 1 and mbr SHALL be high-Z.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 A reset during LOAD SHALL restart loading at address 0.
REQ-031 A reset during RUN SHALL return the block to LOAD.

Structure
REQ-032 Package mem_pkg SHALL hold the state enum {LOAD, RUN} and the default PROT_LIMIT and IO_ADDR constants.
REQ-033 Storage SHALL be sub-module mem_array: 256x8, synchronous write, asynchronous read, with a single write port muxed between loader and bus.
REQ-034 The tri-state mbr driver SHALL live in mem_responder only.

Verification
REQ-035 Reset, then load 8'h41, 8'h52 (ld_last = 1) -> mem[0] = 41, mem[1] = 52; state RUN one edge after the last byte; cpu_hold 1 -> 0.
REQ-036 In RUN, mar = 8'h01, we = 0 -> mbr = 8'h52 in the same cycle; with we = 1 the bench drives mbr and the block does not drive it.
REQ-037 Bus write mar = 8'hF3, mbr = 8'hA5, we high for 3 cycles -> one write; then a read of F3 returns A5; wr_fault = 0.
REQ-038 Bus write mar = 8'h10 with data 8'h00 -> mem[10] unchanged; wr_fault = 1 and stays 1 over later valid writes.
REQ-039 Bus write mar = 8'hFF with data 8'h3C -> io_out = 3C next cycle; a read of FF returns 3C; mem[FF] unchanged.
REQ-040 Stream 256 bytes with ld_last = 0 -> RUN is entered after address FF; reset asserted after 3 bytes -> the next byte is written to address 0.
